// File: rtl/shrimp_regfile_arbiter_if.sv
// Purpose: bundles the two write requesters, the reserve port, the regfile write port and the busy scoreboard.
// Latency: none (wires only); the arbiter registers the regfile write one cycle after the grant.
// Backpressure: x_req_ready is the per-requester grant; a losing requester holds its request until granted.
interface shrimp_regfile_arbiter_if;
  // Requester A (ALU writeback)
  logic        a_req_valid;
  logic [3:0]  a_req_addr;
  logic [7:0]  a_req_val;
  logic        a_req_ready;
  // Requester B (load unit)
  logic        b_req_valid;
  logic [3:0]  b_req_addr;
  logic [7:0]  b_req_val;
  logic        b_req_ready;
  // Destination reservation
  logic        rsv_valid;
  logic [3:0]  rsv_addr;
  // Registered write port towards shrimp_regfile
  logic [3:0]  reg_w_addr;
  logic [7:0]  reg_w_val;
  logic        reg_w_enable;
  // Outstanding-write scoreboard
  logic [15:0] busy;

  // Requester side: drives requests and reservations, observes grants and the write port.
  modport master (
    output a_req_valid, a_req_addr, a_req_val,
    output b_req_valid, b_req_addr, b_req_val,
    output rsv_valid, rsv_addr,
    input  a_req_ready, b_req_ready,
    input  reg_w_addr, reg_w_val, reg_w_enable, busy
  );

  // Arbiter side.
  modport slave (
    input  a_req_valid, a_req_addr, a_req_val,
    input  b_req_valid, b_req_addr, b_req_val,
    input  rsv_valid, rsv_addr,
    output a_req_ready, b_req_ready,
    output reg_w_addr, reg_w_val, reg_w_enable, busy
  );
endinterface

// File: rtl/shrimp_regfile_arbiter.sv
// Purpose: round-robin arbiter merging two regfile write requesters, plus a busy scoreboard for reserved registers.
// Latency: 1 cycle from grant edge to reg_w_enable/addr/val; throughput 1 write per cycle.
// Backpressure: ready is a combinational grant; the loser holds its request. Optional stall counter under SHRIMP_REGARB_STALL_CNT_EN.
module shrimp_regfile_arbiter (
  input  logic                     clock,
  input  logic                     reset_n,
  shrimp_regfile_arbiter_if.slave  bus
`ifdef SHRIMP_REGARB_STALL_CNT_EN
  ,
  output logic [7:0]               stall_count
`endif
);

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] val;
  } wr_t;

  // Round-robin pointer: 0 selects requester A on a tie, 1 selects B.
  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

  logic        ptr_q, ptr_d;
  wr_t         wr_q, wr_d;
  logic        wen_q, wen_d;
  logic [15:0] busy_q, busy_d;
  logic        grant_a, grant_b;

  // Grant decision: lone requester always wins, tie goes to the pointer; nothing is granted while in reset.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (reset_n) begin
      if (bus.a_req_valid && bus.b_req_valid) begin
        grant_a = (ptr_q == PTR_A);
        grant_b = (ptr_q == PTR_B);
      end else begin
        grant_a = bus.a_req_valid;
        grant_b = bus.b_req_valid;
      end
    end
  end

  assign bus.a_req_ready = grant_a;
  assign bus.b_req_ready = grant_b;

  // Next-state: pointer moves to the non-winner, write port captures the winner and pulses enable for one cycle.
  always_comb begin
    ptr_d = ptr_q;
    wr_d  = wr_q;
    wen_d = 1'b0;
    if (grant_a) begin
      ptr_d = PTR_B;
      wr_d  = '{addr: bus.a_req_addr, val: bus.a_req_val};
      wen_d = 1'b1;
    end else if (grant_b) begin
      ptr_d = PTR_A;
      wr_d  = '{addr: bus.b_req_addr, val: bus.b_req_val};
      wen_d = 1'b1;
    end
  end

  // Scoreboard: the write leaving the port this cycle clears its bit; a same-edge reservation re-sets it.
  always_comb begin
    logic [15:0] set_mask;
    logic [15:0] clr_mask;
    set_mask = 16'h0000;
    clr_mask = 16'h0000;
    if (bus.rsv_valid) begin
      set_mask = 16'h0001 << bus.rsv_addr;
    end
    if (wen_q) begin
      clr_mask = 16'h0001 << wr_q.addr;
    end
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  // State registers; async reset drops any captured write so no enable pulse follows release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q  <= PTR_A;
      wr_q   <= '0;
      wen_q  <= 1'b0;
      busy_q <= 16'h0000;
    end else begin
      ptr_q  <= ptr_d;
      wr_q   <= wr_d;
      wen_q  <= wen_d;
      busy_q <= busy_d;
    end
  end

  assign bus.reg_w_addr   = wr_q.addr;
  assign bus.reg_w_val    = wr_q.val;
  assign bus.reg_w_enable = wen_q;
  assign bus.busy         = busy_q;

`ifdef SHRIMP_REGARB_STALL_CNT_EN
  logic [7:0] stall_q, stall_d;
  logic       stall_event;

  // A stall is any valid requester that did not get the grant this cycle.
  assign stall_event = (bus.a_req_valid && !grant_a) || (bus.b_req_valid && !grant_b);

  // Saturating stall counter.
  always_comb begin
    stall_d = stall_q;
    if (stall_event && (stall_q != 8'hFF)) begin
      stall_d = stall_q + 8'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= 8'h00;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_shrimp_regfile_arbiter.sv
// Purpose: self-checking bench for shrimp_regfile_arbiter (vector table plus hand sequences, write scoreboard).
// Latency: expects writes one cycle after each grant, compared in order from a queue.
// Backpressure: losing requesters are held stable until granted; SHRIMP_REGARB_STALL_CNT_EN adds the stall checks.
module tb_shrimp_regfile_arbiter;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  shrimp_regfile_arbiter_if bus();

`ifdef SHRIMP_REGARB_STALL_CNT_EN
  logic [7:0] stall_count;
`endif

  shrimp_regfile_arbiter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef SHRIMP_REGARB_STALL_CNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] val;
  } wr_t;

  typedef struct {
    logic       av;
    logic [3:0] aa;
    logic [7:0] ad;
    logic       bv;
    logic [3:0] ba;
    logic [7:0] bd;
    logic       ea;
    logic       eb;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;
  logic [7:0] rf [16];
  vec_t vt [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Small regfile model: commits on the edge where reg_w_enable is high.
  always @(posedge clock) begin
    if (bus.reg_w_enable === 1'b1) rf[bus.reg_w_addr] <= bus.reg_w_val;
  end

  // Write monitor: every enable pulse must match the oldest expected grant.
  always @(negedge clock) begin
    if (bus.reg_w_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d val 0x%0h, required no write (t=%0t)",
                 bus.reg_w_addr, bus.reg_w_val, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("w_addr", 32'(bus.reg_w_addr), 32'(mon_e.addr));
        chk("w_val",  32'(bus.reg_w_val),  32'(mon_e.val));
      end
    end
  end

  task automatic drive(input logic av, input logic [3:0] aa, input logic [7:0] ad,
                       input logic bv, input logic [3:0] ba, input logic [7:0] bd,
                       input logic rv, input logic [3:0] ra);
    bus.a_req_valid = av;
    bus.a_req_addr  = aa;
    bus.a_req_val   = ad;
    bus.b_req_valid = bv;
    bus.b_req_addr  = ba;
    bus.b_req_val   = bd;
    bus.rsv_valid   = rv;
    bus.rsv_addr    = ra;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Checks grants mid-cycle and, if asked, queues the winner's write for the monitor.
  task automatic check_grant(input string nm, input logic ea, input logic eb, input logic push);
    @(negedge clock);
    chk({nm, "_a_rdy"}, 32'(bus.a_req_ready), 32'(ea));
    chk({nm, "_b_rdy"}, 32'(bus.b_req_ready), 32'(eb));
    if (push && ea) exp_q.push_back({bus.a_req_addr, bus.a_req_val});
    if (push && eb) exp_q.push_back({bus.b_req_addr, bus.b_req_val});
  endtask

  task automatic reset_pulse();
    idle();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    // Vectors applied back to back from reset; pointer starts at A.
    vt[0]  = '{1'b1, 4'd0, 8'd120,  1'b0, 4'd0, 8'd0,    1'b1, 1'b0}; // lone A -> ptr B
    vt[1]  = '{1'b0, 4'd0, 8'd0,    1'b0, 4'd0, 8'd0,    1'b0, 1'b0}; // idle, ptr stays B
    vt[2]  = '{1'b1, 4'd1, 8'd5,    1'b1, 4'd2, 8'd9,    1'b0, 1'b1}; // tie -> B, ptr A
    vt[3]  = '{1'b1, 4'd1, 8'd5,    1'b0, 4'd0, 8'd0,    1'b1, 1'b0}; // held A wins, ptr B
    vt[4]  = '{1'b1, 4'd4, 8'd33,   1'b0, 4'd0, 8'd0,    1'b1, 1'b0}; // lone A again, ptr B
    vt[5]  = '{1'b0, 4'd0, 8'd0,    1'b1, 4'd5, 8'd66,   1'b0, 1'b1}; // lone B, ptr A
    vt[6]  = '{1'b0, 4'd0, 8'd0,    1'b1, 4'd6, 8'd77,   1'b0, 1'b1}; // lone B again, ptr A
    vt[7]  = '{1'b1, 4'd7, 8'h11,   1'b1, 4'd8, 8'h22,   1'b1, 1'b0}; // tie -> A, ptr B
    vt[8]  = '{1'b1, 4'd9, 8'h33,   1'b1, 4'd8, 8'h22,   1'b0, 1'b1}; // tie -> held B, ptr A
    vt[9]  = '{1'b1, 4'd9, 8'h33,   1'b0, 4'd0, 8'd0,    1'b1, 1'b0}; // lone A, ptr B
    vt[10] = '{1'b0, 4'd0, 8'd0,    1'b0, 4'd0, 8'd0,    1'b0, 1'b0};
    vt[11] = '{1'b0, 4'd0, 8'd0,    1'b0, 4'd0, 8'd0,    1'b0, 1'b0};

    // Reset state, with requests and a reservation pushing against it.
    idle();
    reset_n = 1'b0;
    #2;
    drive(1'b1, 4'd3, 8'd7, 1'b1, 4'd4, 8'd8, 1'b1, 4'd2);
    @(negedge clock);
    chk("rst_a_rdy", 32'(bus.a_req_ready), 32'd0);
    chk("rst_b_rdy", 32'(bus.b_req_ready), 32'd0);
    chk("rst_wen",   32'(bus.reg_w_enable), 32'd0);
    chk("rst_waddr", 32'(bus.reg_w_addr), 32'd0);
    chk("rst_wval",  32'(bus.reg_w_val), 32'd0);
    next_cycle();
    chk("rst_busy",  32'(bus.busy), 32'h0000);
    chk("rst_wen2",  32'(bus.reg_w_enable), 32'd0);
    idle();
    reset_n = 1'b1;

    // Table: first vector lands on the first edge after reset release.
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].av, vt[i].aa, vt[i].ad, vt[i].bv, vt[i].ba, vt[i].bd, 1'b0, 4'd0);
      check_grant($sformatf("vec%0d", i), vt[i].ea, vt[i].eb, 1'b1);
      next_cycle();
    end
    chk("hold_wen",   32'(bus.reg_w_enable), 32'd0);
    chk("hold_waddr", 32'(bus.reg_w_addr), 32'd9);
    chk("hold_wval",  32'(bus.reg_w_val), 32'h33);
    chk("rf0_readback", 32'(rf[0]), 32'd120);
    chk("rf8_readback", 32'(rf[8]), 32'h22);
    chk("sb_drain_table", 32'(exp_q.size()), 32'd0);

    // Both requesters valid from reset: A,B,A,B with enable high on consecutive cycles.
    reset_pulse();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 4'd1, 8'd5, 1'b1, 4'd2, 8'd9, 1'b0, 4'd0);
      check_grant($sformatf("rr%0d", k), (k % 2) == 0, (k % 2) == 1, 1'b1);
      if (k > 0) chk("b2b_wen", 32'(bus.reg_w_enable), 32'd1);
      next_cycle();
    end
    idle();
    @(negedge clock);
    chk("b2b_wen_last", 32'(bus.reg_w_enable), 32'd1);
    next_cycle();
    chk("b2b_wen_off", 32'(bus.reg_w_enable), 32'd0);

    // Scoreboard set/clear, set-wins, and no counting of repeated reservations.
    drive(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd3);
    next_cycle();
    chk("busy_rsv3", 32'(bus.busy), 32'h0008);
    drive(1'b0, 4'd0, 8'd0, 1'b1, 4'd3, 8'h44, 1'b0, 4'd0);
    check_grant("busy_wr1", 1'b0, 1'b1, 1'b1);
    next_cycle();
    chk("busy_during_wen", 32'(bus.busy), 32'h0008);
    idle();
    next_cycle();
    chk("busy_cleared", 32'(bus.busy), 32'h0000);
    drive(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd3);
    next_cycle();
    drive(1'b0, 4'd0, 8'd0, 1'b1, 4'd3, 8'h55, 1'b0, 4'd0);
    check_grant("busy_wr2", 1'b0, 1'b1, 1'b1);
    next_cycle();
    drive(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd3);
    next_cycle();
    chk("busy_set_wins", 32'(bus.busy), 32'h0008);
    drive(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd3);
    next_cycle();
    drive(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd15);
    next_cycle();
    chk("busy_rsv15", 32'(bus.busy), 32'h8008);
    drive(1'b0, 4'd0, 8'd0, 1'b1, 4'd3, 8'h66, 1'b0, 4'd0);
    check_grant("busy_wr3", 1'b0, 1'b1, 1'b1);
    next_cycle();
    idle();
    next_cycle();
    chk("busy_single_clear", 32'(bus.busy), 32'h8000);
    chk("rf3_readback", 32'(rf[3]), 32'h66);

    // Reset while a captured write is on the port: it must vanish for good.
    reset_pulse();
    drive(1'b1, 4'd6, 8'hAB, 1'b0, 4'd0, 8'd0, 1'b1, 4'd5);
    check_grant("rstmid", 1'b1, 1'b0, 1'b0);
    next_cycle();
    chk("rstmid_captured", 32'(bus.reg_w_enable), 32'd1);
    chk("rstmid_busy_pre", 32'(bus.busy), 32'h0020);
    idle();
    reset_n = 1'b0;
    #1;
    chk("rstmid_wen",  32'(bus.reg_w_enable), 32'd0);
    chk("rstmid_busy", 32'(bus.busy), 32'h0000);
    next_cycle();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("post_rst_wen",   32'(bus.reg_w_enable), 32'd0);
      chk("post_rst_waddr", 32'(bus.reg_w_addr), 32'd0);
      chk("post_rst_wval",  32'(bus.reg_w_val), 32'd0);
      chk("post_rst_busy",  32'(bus.busy), 32'h0000);
      next_cycle();
    end

`ifdef SHRIMP_REGARB_STALL_CNT_EN
    // Continuous contention: one stall per edge, saturating at 255.
    reset_pulse();
    chk("stall_rst", 32'(stall_count), 32'd0);
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, 4'd1, 8'd5, 1'b1, 4'd2, 8'd9, 1'b0, 4'd0);
      check_grant("stall_rr", (k % 2) == 0, (k % 2) == 1, 1'b1);
      next_cycle();
      if (k == 9) chk("stall_10", 32'(stall_count), 32'd10);
    end
    chk("stall_sat", 32'(stall_count), 32'd255);
    idle();
    next_cycle();
    chk("stall_hold", 32'(stall_count), 32'd255);
`endif

    idle();
    @(negedge clock);
    next_cycle();
    chk("sb_drain_final", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shrimp_regfile_arbiter.md
SHRIMP_REGFILE_ARBITER -- requirements
Module: shrimp_regfile_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and a reset that is asynchronous and active-low.
REQ-002 clock  in  1  rising-edge system clock, same clock as shrimp_regfile.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 a_req_valid  in  1  requester A (ALU writeback) has a write pending.
REQ-005 a_req_addr  in  4  requester A destination register.
REQ-006 a_req_val  in  8  requester A write data.
REQ-007 a_req_ready  out  1  requester A granted this cycle.
REQ-008 b_req_valid  in  1  requester B (load unit) has a write pending.
REQ-009 b_req_addr  in  4  requester B destination register.
REQ-010 b_req_val  in  8  requester B write data.
REQ-011 b_req_ready  out  1  requester B granted this cycle.
REQ-012 rsv_valid  in  1  reserve (mark busy) a destination register this cycle.
REQ-013 rsv_addr  in  4  register to reserve.
REQ-014 reg_w_addr  out  4  to shrimp_regfile reg_w_addr, registered.
REQ-015 reg_w_val  out  8  to shrimp_regfile reg_w_val, registered.
REQ-016 reg_w_enable  out  1  to shrimp_regfile reg_w_enable, registered.
REQ-017 busy  out  16  scoreboard; bit i set = register i has an outstanding write.

Function
REQ-018 A transfer SHALL occur on a rising edge where x_req_valid and x_req_ready are both 1; at most one transfer per cycle.
REQ-019 x_req_ready SHALL be combinational from the valids and the round-robin pointer; x_req_ready=0 whenever x_req_valid=0.
REQ-020 Only one valid: that requester SHALL be granted; the pointer SHALL then point to the other requester.
REQ-021 Both valid: the requester selected by the pointer SHALL be granted; the pointer SHALL flip to the loser.
REQ-022 Neither valid: no grant, pointer unchanged.
REQ-023 A losing requester SHALL hold valid, addr and val stable until granted; the arbiter is not required to tolerate retraction.
REQ-024 On a transfer edge, reg_w_addr/reg_w_val SHALL capture the winner's addr/val and reg_w_enable SHALL become 1 for exactly the following cycle (1-cycle latency); the regfile commits on the next edge.
REQ-025 Cycles with no transfer SHALL drive reg_w_enable=0; reg_w_addr/reg_w_val SHALL hold their last values.
REQ-026 Back-to-back transfers SHALL produce reg_w_enable=1 on consecutive cycles (throughput 1 write/cycle).
REQ-027 busy[rsv_addr] SHALL set on an edge with rsv_valid=1.
REQ-028 busy[reg_w_addr] SHALL clear on an edge with reg_w_enable=1.
REQ-029 Reserve and clear of the same register on the same edge: set SHALL win (busy stays 1).
REQ-030 Reserving an already-busy register SHALL leave it busy; no counting of multiple reservations.
REQ-031 Writes to non-busy registers SHALL be performed normally; busy bits do not gate grants.

Reset
REQ-032 While reset_n=0: reg_w_enable=0, reg_w_addr=0, reg_w_val=0, busy=16'h0000, pointer=A, both ready outputs 0.
REQ-033 Reset asserted mid-transfer SHALL discard the captured write; no reg_w_enable pulse after release until a new transfer.
REQ-034 First edge after reset_n rises SHALL arbitrate normally.

Configuration
REQ-035 Macro SHRIMP_REGARB_STALL_CNT_EN defined: add output stall_count (8 bits), incremented on every edge where a requester is valid and not granted, saturating at 255, reset to 0.
REQ-036 Macro undefined: stall_count port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-037 Reset, then A valid addr=0 val=120, B idle -> a_req_ready=1; next cycle reg_w_enable=1, reg_w_addr=0, reg_w_val=120; reading reg 0 afterwards returns 120.
REQ-038 A (addr=1,val=5) and B (addr=2,val=9) valid continuously from reset -> grants A,B,A,B; reg_w_enable high every cycle; addr sequence 1,2,1,2.
REQ-039 rsv_valid addr=3 -> busy=16'h0008; B writes addr=3 -> busy[3] clears on the edge reg_w_enable=1; simultaneous rsv addr=3 on that edge -> busy[3] stays 1.
REQ-040 reset_n pulsed low one cycle after an A transfer -> reg_w_enable never rises, busy=0, outputs zero.
REQ-041 With SHRIMP_REGARB_STALL_CNT_EN, both valid for 300 cycles -> stall_count saturates at 255; without macro the bench compiles with port omitted.
